// File: rtl/vx_credit_gate_pkg.sv
// VX_credit_pkg: shared types and constants for the credit gate slice.
// Imported by vx_credit_counter and vx_credit_gate.
package VX_credit_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } crd_state_t;

  localparam int PERF_CTR_W = 32;

endpackage

// File: rtl/vx_credit_gate_counter.sv
// vx_credit_counter: credit register, next-count arithmetic and idle flag.
// Overflow/underflow checks are simulation-only immediate assertions.
module vx_credit_counter
  import VX_credit_pkg::*;
#(
  parameter int CREDITS = 4,
  parameter int RETW    = 1,
  parameter int CNTW    = $clog2(CREDITS + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fire,
  input  logic [RETW-1:0] crd_ret,
  output logic [CNTW-1:0] credits,
  output logic            idle
);

  localparam logic [CNTW-1:0] FULL   = CNTW'(CREDITS);
  localparam logic [CNTW:0]   FULL_W = (CNTW + 1)'(CREDITS);

  logic [CNTW-1:0] credits_n;
  logic [CNTW:0]   credits_w;

  // credits_w carries one spare bit so a wrapped sum is still visible
  always_comb begin
    credits_n = credits - CNTW'(fire) + CNTW'(crd_ret);
    credits_w = {1'b0, credits} - (CNTW + 1)'(fire)
              + (CNTW + 1)'(crd_ret);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credits <= FULL;
      idle    <= 1'b1;
    end else begin
      credits <= credits_n;
      idle    <= (credits_n == FULL);
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (credits_w <= FULL_W)
        else $error("credit overflow");
      assert (!(fire && credits == '0))
        else $error("credit underflow");
    end
  end
`endif

endmodule

// File: rtl/vx_credit_gate.sv
// vx_credit_gate: credit-gated valid/ready transmit path with flush FSM.
// Define CREDIT_GATE_PERF_EN to add the perf_stalls counter port.
module vx_credit_gate
  import VX_credit_pkg::*;
#(
  parameter int CREDITS = 4,
  parameter int RETW    = 1,
  parameter int DATAW   = 32,
  parameter int CNTW    = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [DATAW-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DATAW-1:0] out_data,
  input  logic             out_ready,
  input  logic [RETW-1:0]  crd_ret,
  input  logic             flush_req,
  output logic             flush_done,
  output logic [CNTW-1:0]  credits,
  output logic             idle
`ifdef CREDIT_GATE_PERF_EN
  ,
  output logic [PERF_CTR_W-1:0] perf_stalls
`endif
);

  localparam logic [CNTW-1:0] FULL = CNTW'(CREDITS);

  crd_state_t state, state_n;
  logic       has_crd;
  logic       fire;

  assign has_crd  = (credits != '0);
  assign out_data = in_data;
  assign fire     = out_valid & out_ready;

  // gating uses only the registered count, never crd_ret
  always_comb begin
    state_n   = state;
    out_valid = 1'b0;
    in_ready  = 1'b0;
    unique case (state)
      RUN: begin
        out_valid = in_valid & has_crd & ~reset;
        in_ready  = out_ready & has_crd & ~reset;
        if (flush_req) state_n = DRAIN;
      end
      DRAIN: begin
        if (credits == FULL) state_n = DONE;
      end
      DONE: begin
        state_n = RUN;
      end
      default: begin
        state_n = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_n;
  end

  assign flush_done = (state == DONE) & ~reset;

  vx_credit_counter #(
    .CREDITS (CREDITS),
    .RETW    (RETW),
    .CNTW    (CNTW)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .fire    (fire),
    .crd_ret (crd_ret),
    .credits (credits),
    .idle    (idle)
  );

`ifdef CREDIT_GATE_PERF_EN
  always_ff @(posedge clk) begin
    if (reset)
      perf_stalls <= '0;
    else if (state == RUN && in_valid && !has_crd)
      perf_stalls <= perf_stalls + PERF_CTR_W'(1);
  end
`endif

endmodule

// File: doc/vx_credit_gate.md
# vx_credit_gate

Credit-based transmit gate for the initiator side of a valid/ready link into a responder with a bounded buffer. It holds a local credit count and forwards a request only when a credit is available. The responder returns credits as it drains its buffer. A flush FSM blocks new traffic and signals when every outstanding credit has come back. The block sits between a request source and any responder that tracks occupancy with a pending-size counter.

## Interface
Parameters:
- CREDITS, 4, responder buffer depth; reset credit count (≥1)
- RETW, 1, width of credit-return field; up to 2^RETW−1 credits returned per cycle (RETW ≤ CNTW)
- DATAW, 32, request payload width
- CNTW, CLOG2(CREDITS+1), credit counter width (derived)

Ports (reset: reset, synchronous, active-high; clock: clk):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  upstream request valid
- in_data  in  DATAW  upstream payload
- in_ready  out  1  upstream ready
- out_valid  out  1  request to responder
- out_data  out  DATAW  payload to responder (= in_data)
- out_ready  in  1  responder accept
- crd_ret  in  RETW  number of credits returned this cycle
- flush_req  in  1  level; request drain of all outstanding credits
- flush_done  out  1  one-cycle pulse; all CREDITS returned
- credits  out  CNTW  current credit count (registered)
- idle  out  1  registered, credits == CREDITS
- perf_stalls  out  32  present only with CREDIT_GATE_PERF_EN

## Operation
- FSM states RUN, DRAIN, DONE; reset → RUN.
- RUN:
  - out_valid = in_valid & (credits != 0).
  - in_ready = out_ready & (credits != 0).
  - fire = out_valid & out_ready.
- DRAIN and DONE: out_valid = 0, in_ready = 0.
- Credit update every cycle: credits_n = credits − fire + crd_ret, computed in CNTW bits.
- Assert credits_n ≤ CREDITS (overflow: too many returns). Underflow is impossible by gating; assert anyway.
- crd_ret has no combinational path to out_valid or in_ready. A credit returned while credits == 0 enables a send in the next cycle.
- Same-cycle send and return net out: credits = 1, fire, crd_ret = 1 → credits stays 1.
- Transitions:
  - RUN → DRAIN when flush_req = 1. A fire in that same cycle still completes.
  - DRAIN → DONE when the registered credits == CREDITS.
  - DONE → RUN unconditionally after one cycle.
- flush_done = (state == DONE).
- flush_req is ignored in DRAIN and DONE. If flush_req is still high in DONE, the FSM returns to RUN and re-enters DRAIN on the next cycle.
- Credit returns continue to be counted in every state.
- Reset values: credits = CREDITS, idle = 1, flush_done = 0, out_valid = 0, in_ready = 0 while in reset, perf_stalls = 0.
- Reset mid-operation discards in-flight accounting. The responder must be reset in the same cycle.

## Timing
- Request path is fully combinational: in→out latency 0 cycles. No payload storage.
- credits and idle reflect fire/crd_ret one cycle later.
- Flush with all credits home: flush_req at cycle t → DRAIN at t+1 → flush_done at t+2 → RUN at t+3.
- Flush with k credits outstanding: flush_done occurs one cycle after the cycle in which credits first reads CREDITS.

## Configuration
- CREDIT_GATE_PERF_EN defined:
  - 32-bit perf_stalls increments every cycle in RUN where in_valid & (credits == 0).
  - Wraps at 2^32; reset to 0.
- Not defined: perf_stalls port and counter are absent, with no extra logic.

## Structure
- Shared package VX_credit_pkg:
  - crd_state_t enum {RUN, DRAIN, DONE}, 2 bits.
  - Perf counter width constant PERF_CTR_W = 32.
- One natural sub-module, vx_credit_counter:
  - Holds credits register, credits_n arithmetic, overflow/underflow asserts, and the idle flag.
  - Parameterized by CREDITS and RETW.
- FSM, handshake gating and perf counter stay in vx_credit_gate.

## Test plan
- Exhaust credits: CREDITS = 4, out_ready = 1, in_valid held with no returns → exactly 4 fires; credits 4→0; out_valid = 0 from cycle 5; in_ready = 0.
- Return at zero: credits = 0, crd_ret = 1 at cycle t → out_valid = 0 at t, 1 at t+1; credits = 1 at t+1.
- Simultaneous: credits = 2, fire and crd_ret = 1 in the same cycle → credits stays 2. With RETW = 2 and crd_ret = 3 while credits = 1 and no fire → credits = 4, idle = 1.
- Flush with outstanding: 3 credits out, flush_req pulse → out_valid = 0 from next cycle. Return 1 credit per cycle → flush_done single pulse one cycle after credits = 4, then RUN.
- Overflow check: credits = 4, crd_ret = 1 → assertion fires.
- Perf: with CREDIT_GATE_PERF_EN, hold in_valid for 10 cycles at credits = 0 → perf_stalls = 10; without the macro the build has no perf_stalls port.
